// File: rtl/bnn_conv_stream.sv
`default_nettype none
// =============================================================================
// bnn_conv_stream : streaming XNOR-popcount KxK "valid" convolution over binary
// rows. Optional macro BNN_CONV_RAW_SUM_EN adds the out_sum port. Rev 1.0
// =============================================================================
module bnn_conv_stream #(
  parameter int K      = 3,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int THRESH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_load,
  input  logic [K*K-1:0]         w_data,
  output logic                   w_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMG_W-1:0]       in_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IMG_W-K:0]       out_row,
`ifdef BNN_CONV_RAW_SUM_EN
  output logic [(IMG_W-K+1)*$clog2(K*K+1)-1:0] out_sum,
`endif
  output logic                   out_last
);

  localparam int OW  = IMG_W - K + 1;
  localparam int SW  = $clog2(K*K + 1);
  localparam int RCW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic [K*K-1:0] w_q, w_d;
  logic           w_err_q, w_err_d;
  // Only K-1 rows are stored; the incoming row is always the newest window row.
  logic [K-2:0][IMG_W-1:0] lbuf_q, lbuf_d;
  logic           out_valid_q, out_valid_d;
  logic [OW-1:0]  out_row_q, out_row_d;
  logic           out_last_q, out_last_d;

  logic                   row_acc;
  logic                   w_ok;
  logic                   last_row;
  logic [K-1:0][IMG_W-1:0] win;
  logic [SW-1:0]          sum_w [OW];
  logic [OW-1:0]          hit_w;

  assign in_ready = (state_q != S_IDLE) & (!out_valid_q | out_ready);
  assign row_acc  = in_valid & in_ready;
  assign w_ok     = (state_q == S_IDLE) | ((state_q == S_FILL) & (row_cnt_q == '0));
  assign last_row = (row_cnt_q == RCW'(IMG_H - 1));
  assign win      = {in_row, lbuf_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_load) state_d = S_FILL;
      S_FILL:   if (row_acc && (row_cnt_q == RCW'(K - 2))) state_d = S_STREAM;
      S_STREAM: if (row_acc && last_row) state_d = S_FILL;
      default:  state_d = S_IDLE;
    endcase
  end

  // Kernel, error flag, row counter and line buffer
  always_comb begin
    w_d       = w_q;
    w_err_d   = w_err_q;
    row_cnt_d = row_cnt_q;
    lbuf_d    = lbuf_q;
    if (w_load) begin
      if (w_ok) w_d = w_data;
      else      w_err_d = 1'b1;
    end
    if (row_acc) begin
      for (int r = 0; r < K - 2; r++) begin
        lbuf_d[r] = lbuf_q[r+1];
      end
      lbuf_d[K-2] = in_row;
      row_cnt_d   = last_row ? '0 : row_cnt_q + RCW'(1);
    end
  end

  // XNOR-popcount per output pixel over the window ending at the incoming row
  always_comb begin
    hit_w = '0;
    for (int j = 0; j < OW; j++) begin
      sum_w[j] = '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          sum_w[j] = sum_w[j] + {{(SW-1){1'b0}}, ~(win[r][j+c] ^ w_q[r*K+c])};
        end
      end
      hit_w[j] = (sum_w[j] >= SW'(THRESH));
    end
  end

`ifdef BNN_CONV_RAW_SUM_EN
  logic [OW*SW-1:0] out_sum_q, out_sum_d;
  assign out_sum = out_sum_q;
`endif

  // Output register: load on a streaming accept, otherwise drain on handshake
  always_comb begin
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
`ifdef BNN_CONV_RAW_SUM_EN
    out_sum_d   = out_sum_q;
`endif
    if (row_acc && (state_q == S_STREAM)) begin
      out_valid_d = 1'b1;
      out_row_d   = hit_w;
      out_last_d  = last_row;
`ifdef BNN_CONV_RAW_SUM_EN
      for (int j = 0; j < OW; j++) begin
        out_sum_d[j*SW +: SW] = sum_w[j];
      end
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q   <= '0;
      w_q         <= '0;
      w_err_q     <= 1'b0;
      lbuf_q      <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef BNN_CONV_RAW_SUM_EN
      out_sum_q   <= '0;
`endif
    end else begin
      row_cnt_q   <= row_cnt_d;
      w_q         <= w_d;
      w_err_q     <= w_err_d;
      lbuf_q      <= lbuf_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
`ifdef BNN_CONV_RAW_SUM_EN
      out_sum_q   <= out_sum_d;
`endif
    end
  end

  assign w_err     = w_err_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire
